edge_detect_multi: RTL and testbench

Parametrised multi-channel edge detector for the USB receiver datapath and general-purpose asynchronous inputs. Each channel synchronises its input through a configurable flop chain and optionally rejects glitches with a per-channel stability filter. It then emits a one-cycle edge pulse qualified by a per-channel mode, plus a sticky event flag. It generalises the single-channel D+ edge detector: N channels, selectable rising/falling/both, glitch filtering, and optional saturating event counters.

---
 rtl/edge_detect_multi.sv | 120 ++++++++++++
 tb/tb_edge_detect_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector for USB receive and general-purpose async inputs.
// Each channel passes through a synchroniser chain and an optional stability
// filter. It then produces a mode-qualified one-cycle edge pulse, a sticky
// event flag and, optionally, a saturating event counter.
//
// Optional feature: define EDGE_DET_COUNT_EN to build the per-channel event
// counters. When it is not defined, edge_cnt is tied to zero and cnt_clr is
// ignored.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   d_in       raw asynchronous inputs, one per channel
//   mode       per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
//   flag_clr   per-channel synchronous clear of edge_flag
//   cnt_clr    synchronous clear of all event counters
//   d_sync     filtered, synchronised level per channel
//   d_edge     registered one-cycle qualified edge pulse
//   edge_flag  sticky event flag (a set wins over flag_clr)
//   edge_cnt   saturating event counters, channel i at [CNT_W*i +: CNT_W]
module edge_detect_multi #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 0,
   parameter logic        IDLE_VAL    = 1'b1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [NUM_CH-1:0]       d_in,
   input  logic [2*NUM_CH-1:0]     mode,
   input  logic [NUM_CH-1:0]       flag_clr,
   input  logic                    cnt_clr,
   output logic [NUM_CH-1:0]       d_sync,
   output logic [NUM_CH-1:0]       d_edge,
   output logic [NUM_CH-1:0]       edge_flag,
   output logic [NUM_CH*CNT_W-1:0] edge_cnt
);

   localparam int unsigned     FC_W   = 8;
   localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILTER_LEN);

   logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q;
   logic [NUM_CH-1:0][FC_W-1:0]        fc_q;
   logic [NUM_CH-1:0][FC_W-1:0]        fc_nxt;
   logic [NUM_CH-1:0]                  s_last;
   logic [NUM_CH-1:0]                  change;
   logic [NUM_CH-1:0]                  edge_nxt;

   // Filter decision: a new level is accepted once it has persisted for
   // FILTER_LEN extra evaluations; any return to the current level restarts it.
   always_comb begin
      s_last   = '0;
      change   = '0;
      edge_nxt = '0;
      fc_nxt   = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         s_last[i] = sync_q[i][SYNC_STAGES-1];
         if (s_last[i] == d_sync[i]) begin
            fc_nxt[i] = '0;
         end else if (fc_q[i] == FC_MAX) begin
            change[i] = 1'b1;
            fc_nxt[i] = '0;
         end else begin
            fc_nxt[i] = fc_q[i] + FC_W'(1);
         end
         // The new level is s_last: 1 means rising, 0 means falling.
         edge_nxt[i] = change[i] & (s_last[i] ? mode[2*i] : mode[2*i+1]);
      end
   end

   // Synchroniser, filtered level, edge pulse and sticky flag.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q    <= {(NUM_CH*SYNC_STAGES){IDLE_VAL}};
         d_sync    <= {NUM_CH{IDLE_VAL}};
         fc_q      <= '0;
         d_edge    <= '0;
         edge_flag <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], d_in[i]};
            if (change[i]) begin
               d_sync[i] <= s_last[i];
            end
         end
         fc_q      <= fc_nxt;
         d_edge    <= edge_nxt;
         edge_flag <= d_edge | (edge_flag & ~flag_clr);
      end
   end

`ifdef EDGE_DET_COUNT_EN
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

   // Saturating per-channel event counters; a clear coincident with a pulse
   // leaves that pulse counted.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cnt_clr) begin
               cnt_q[i] <= CNT_W'(d_edge[i]);
            end else if (d_edge[i] && (cnt_q[i] != '1)) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign edge_cnt = cnt_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign edge_cnt       = '0;
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
module tb_edge_detect_multi;

   logic        clk;
   logic        n_rst;
   logic [3:0]  d_in;
   logic [7:0]  mode;
   logic [3:0]  flag_clr;
   logic        cnt_clr;
   logic [3:0]  d_sync;
   logic [3:0]  d_edge;
   logic [3:0]  edge_flag;
   logic [31:0] edge_cnt;

   logic [0:0]  d_f;
   logic [1:0]  mode_f;
   logic [0:0]  fclr_f;
   logic        cnt_clr_f;
   logic [0:0]  d_sync_f;
   logic [0:0]  d_edge_f;
   logic [0:0]  flag_f;
   logic [1:0]  cnt_f;

   int n_cmp = 0;
   int n_err = 0;
   int pc[4];
   int pcf;

`ifdef EDGE_DET_COUNT_EN
   localparam logic [31:0] EXP_CNT_REL  = 32'h0101_0101;
   localparam logic [31:0] EXP_CNT_FLAG = 32'h0108_0202;
   localparam logic [1:0]  EXP_F_SAT    = 2'd3;
   localparam logic [1:0]  EXP_F_COINC  = 2'd1;
`else
   localparam logic [31:0] EXP_CNT_REL  = 32'h0;
   localparam logic [31:0] EXP_CNT_FLAG = 32'h0;
   localparam logic [1:0]  EXP_F_SAT    = 2'd0;
   localparam logic [1:0]  EXP_F_COINC  = 2'd0;
`endif

   edge_detect_multi u_dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .d_in      (d_in),
      .mode      (mode),
      .flag_clr  (flag_clr),
      .cnt_clr   (cnt_clr),
      .d_sync    (d_sync),
      .d_edge    (d_edge),
      .edge_flag (edge_flag),
      .edge_cnt  (edge_cnt)
   );

   edge_detect_multi #(
      .NUM_CH     (1),
      .FILTER_LEN (3),
      .CNT_W      (2)
   ) u_flt (
      .clk       (clk),
      .n_rst     (n_rst),
      .d_in      (d_f),
      .mode      (mode_f),
      .flag_clr  (fclr_f),
      .cnt_clr   (cnt_clr_f),
      .d_sync    (d_sync_f),
      .d_edge    (d_edge_f),
      .edge_flag (flag_f),
      .edge_cnt  (cnt_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_count(input int n);
      for (int c = 0; c < 4; c++) pc[c] = 0;
      pcf = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         for (int c = 0; c < 4; c++) if (d_edge[c]) pc[c]++;
         if (d_edge_f[0]) pcf++;
      end
   endtask

   task automatic test_reset;
      n_rst = 1'b0; d_in = 4'h0; mode = 8'hFF; flag_clr = 4'h0; cnt_clr = 1'b0;
      d_f = 1'b1; mode_f = 2'b11; fclr_f = 1'b0; cnt_clr_f = 1'b0;
      #1;
      step(2);
      n_cmp++; if (d_sync !== 4'hF) begin n_err++; $display("FAIL rst_d_sync got %h exp F", d_sync); end
      n_cmp++; if (d_edge !== 4'h0) begin n_err++; $display("FAIL rst_d_edge got %h exp 0", d_edge); end
      n_cmp++; if (edge_flag !== 4'h0) begin n_err++; $display("FAIL rst_flag got %h exp 0", edge_flag); end
      n_cmp++; if (edge_cnt !== 32'h0) begin n_err++; $display("FAIL rst_cnt got %h exp 0", edge_cnt); end
      n_cmp++; if (d_sync_f !== 1'b1) begin n_err++; $display("FAIL rst_flt_sync got %b exp 1", d_sync_f); end
      n_rst = 1'b1;
      step(2);
      n_cmp++; if (d_edge !== 4'h0) begin n_err++; $display("FAIL rel_early_edge got %h exp 0", d_edge); end
      step(1);
      n_cmp++; if (d_edge !== 4'hF) begin n_err++; $display("FAIL rel_edge3 got %h exp F", d_edge); end
      n_cmp++; if (d_sync !== 4'h0) begin n_err++; $display("FAIL rel_sync got %h exp 0", d_sync); end
      step(1);
      n_cmp++; if (d_edge !== 4'h0) begin n_err++; $display("FAIL rel_edge4 got %h exp 0", d_edge); end
      n_cmp++; if (edge_flag !== 4'hF) begin n_err++; $display("FAIL rel_flag got %h exp F", edge_flag); end
      n_cmp++; if (edge_cnt !== EXP_CNT_REL) begin n_err++; $display("FAIL rel_cnt got %h exp %h", edge_cnt, EXP_CNT_REL); end
      n_cmp++; if (d_edge_f !== 1'b0) begin n_err++; $display("FAIL rel_flt_edge got %b exp 0", d_edge_f); end
   endtask

   task automatic test_mode;
      int exp_fall[4] = '{0, 1, 1, 0};
      int exp_rise[4] = '{1, 0, 1, 0};
      mode = 8'h00;
      d_in = 4'hF;
      run_count(6);
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if (pc[c] !== 0) begin n_err++; $display("FAIL mode_off ch%0d pulses %0d exp 0", c, pc[c]); end
      end
      n_cmp++; if (d_sync !== 4'hF) begin n_err++; $display("FAIL mode_off_sync got %h exp F", d_sync); end
      mode = 8'h39;
      d_in = 4'h0;
      run_count(6);
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if (pc[c] !== exp_fall[c]) begin n_err++; $display("FAIL mode_fall ch%0d pulses %0d exp %0d", c, pc[c], exp_fall[c]); end
      end
      n_cmp++; if (d_sync !== 4'h0) begin n_err++; $display("FAIL mode_fall_sync got %h exp 0", d_sync); end
      d_in = 4'hF;
      run_count(6);
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if (pc[c] !== exp_rise[c]) begin n_err++; $display("FAIL mode_rise ch%0d pulses %0d exp %0d", c, pc[c], exp_rise[c]); end
      end
      n_cmp++; if (d_sync !== 4'hF) begin n_err++; $display("FAIL mode_rise_sync got %h exp F", d_sync); end
   endtask

   task automatic test_back_to_back;
      logic [9:0] hist;
      logic [3:0] other;
      logic [3:0] pat;
      hist  = '0;
      other = '0;
      for (int k = 0; k < 10; k++) begin
         pat = 4'hF;
         if (k < 4 && (k % 2) == 0) pat = 4'b1011;
         d_in = pat;
         @(posedge clk);
         #1;
         hist[k] = d_edge[2];
         other   = other | (d_edge & 4'b1011);
      end
      n_cmp++; if (hist !== 10'h03C) begin n_err++; $display("FAIL b2b_pulses got %b exp %b", hist, 10'h03C); end
      n_cmp++; if (other !== 4'h0) begin n_err++; $display("FAIL b2b_other got %h exp 0", other); end
   endtask

   task automatic test_flag;
      flag_clr = 4'b0100;
      step(1);
      n_cmp++; if (edge_flag !== 4'b1011) begin n_err++; $display("FAIL flag_clr2 got %b exp 1011", edge_flag); end
      flag_clr = 4'hF;
      step(1);
      n_cmp++; if (edge_flag !== 4'h0) begin n_err++; $display("FAIL flag_clr_all got %b exp 0000", edge_flag); end
      flag_clr = 4'h0;
      d_in = 4'b1011;
      step(3);
      n_cmp++; if (d_edge !== 4'b0100) begin n_err++; $display("FAIL flag_pulse got %b exp 0100", d_edge); end
      flag_clr = 4'b0100;
      step(1);
      n_cmp++; if (edge_flag !== 4'b0100) begin n_err++; $display("FAIL flag_set_wins got %b exp 0100", edge_flag); end
      flag_clr = 4'h0;
      step(1);
      n_cmp++; if (edge_flag !== 4'b0100) begin n_err++; $display("FAIL flag_sticky got %b exp 0100", edge_flag); end
      flag_clr = 4'b0100;
      step(1);
      n_cmp++; if (edge_flag !== 4'h0) begin n_err++; $display("FAIL flag_cleared got %b exp 0000", edge_flag); end
      flag_clr = 4'h0;
      n_cmp++; if (edge_cnt !== EXP_CNT_FLAG) begin n_err++; $display("FAIL main_cnt got %h exp %h", edge_cnt, EXP_CNT_FLAG); end
      d_in = 4'hF;
      step(6);
   endtask

   task automatic test_glitch;
      d_f = 1'b0;
      step(3);
      d_f = 1'b1;
      run_count(10);
      n_cmp++; if (pcf !== 0) begin n_err++; $display("FAIL glitch_pulses got %0d exp 0", pcf); end
      n_cmp++; if (d_sync_f !== 1'b1) begin n_err++; $display("FAIL glitch_sync got %b exp 1", d_sync_f); end
      d_f = 1'b0;
      step(5);
      n_cmp++; if (d_edge_f !== 1'b0 || d_sync_f !== 1'b1) begin n_err++; $display("FAIL filt_early edge %b sync %b exp 0 1", d_edge_f, d_sync_f); end
      step(1);
      n_cmp++; if (d_edge_f !== 1'b1 || d_sync_f !== 1'b0) begin n_err++; $display("FAIL filt_accept edge %b sync %b exp 1 0", d_edge_f, d_sync_f); end
      step(1);
      n_cmp++; if (d_edge_f !== 1'b0 || flag_f !== 1'b1) begin n_err++; $display("FAIL filt_after edge %b flag %b exp 0 1", d_edge_f, flag_f); end
   endtask

   task automatic test_counter;
      cnt_clr_f = 1'b1;
      step(1);
      cnt_clr_f = 1'b0;
      n_cmp++; if (cnt_f !== 2'd0) begin n_err++; $display("FAIL cnt_clr got %0d exp 0", cnt_f); end
      for (int e = 0; e < 5; e++) begin
         d_f = ((e % 2) == 0) ? 1'b1 : 1'b0;
         step(8);
      end
      n_cmp++; if (cnt_f !== EXP_F_SAT) begin n_err++; $display("FAIL cnt_sat got %0d exp %0d", cnt_f, EXP_F_SAT); end
      n_cmp++; if (d_sync_f !== 1'b1) begin n_err++; $display("FAIL cnt_sync got %b exp 1", d_sync_f); end
      d_f = 1'b0;
      step(6);
      n_cmp++; if (d_edge_f !== 1'b1) begin n_err++; $display("FAIL cnt_pulse got %b exp 1", d_edge_f); end
      cnt_clr_f = 1'b1;
      step(1);
      cnt_clr_f = 1'b0;
      n_cmp++; if (cnt_f !== EXP_F_COINC) begin n_err++; $display("FAIL cnt_coinc got %0d exp %0d", cnt_f, EXP_F_COINC); end
      cnt_clr = 1'b1;
      step(1);
      cnt_clr = 1'b0;
      n_cmp++; if (edge_cnt !== 32'h0) begin n_err++; $display("FAIL main_cnt_clr got %h exp 0", edge_cnt); end
   endtask

   task automatic test_reset_mid_filter;
      d_f = 1'b1;
      step(8);
      d_f = 1'b0;
      step(4);
      d_f  = 1'b1;
      d_in = 4'hF;
      n_rst = 1'b0;
      #1;
      n_cmp++; if (d_sync !== 4'hF || d_edge !== 4'h0) begin n_err++; $display("FAIL mid_rst_main sync %h edge %h exp F 0", d_sync, d_edge); end
      n_cmp++; if (edge_flag !== 4'h0 || edge_cnt !== 32'h0) begin n_err++; $display("FAIL mid_rst_main flag %h cnt %h exp 0 0", edge_flag, edge_cnt); end
      n_cmp++; if (d_sync_f !== 1'b1 || d_edge_f !== 1'b0 || flag_f !== 1'b0) begin n_err++; $display("FAIL mid_rst_flt sync %b edge %b flag %b exp 1 0 0", d_sync_f, d_edge_f, flag_f); end
      step(2);
      n_rst = 1'b1;
      run_count(12);
      n_cmp++; if (pcf !== 0 || d_sync_f !== 1'b1) begin n_err++; $display("FAIL mid_rst_rel pulses %0d sync %b exp 0 1", pcf, d_sync_f); end
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if (pc[c] !== 0) begin n_err++; $display("FAIL mid_rst_main ch%0d pulses %0d exp 0", c, pc[c]); end
      end
   endtask

   initial begin
      test_reset();
      test_mode();
      test_back_to_back();
      test_flag();
      test_glitch();
      test_counter();
      test_reset_mid_filter();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
